ser_tx_shift: RTL

- Parallel-to-serial transmitter, MSB first. It is the transmit counterpart of the serial-in, shift-left capture register used by the divider datapath.
- Accepts one WIDTH-bit word per frame over a valid/ready load handshake, then shifts it out one bit per accepted serial beat.
- Sits between a processor-side producer (debug/IO word port) and any serial-in shift-register receiver.

---
 rtl/ser_tx_shift_pkg.sv | 25 ++
 rtl/ser_tx_shift_if.sv | 26 ++
 rtl/ser_tx_shift_shreg.sv | 32 +++
 rtl/ser_tx_shift.sv | 99 +++++++++
 4 files changed

// File: rtl/ser_tx_shift_pkg.sv
// Shared constants and state encoding for the serial transmit/receive pair.
// Frame length depends on the SER_TX_PARITY_EN macro (adds one parity beat).
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } serState_e;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

`ifdef SER_TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // A receiver built against this package sees the same frame length.
   function automatic int frameLen(input int width);
      return width + PARITY_BITS;
   endfunction

endpackage

// File: rtl/ser_tx_shift_if.sv
// Load handshake and serial beat signals between producer, transmitter and receiver.
// The master side is the environment (producer plus receiver); the slave side is the transmitter.
interface ser_tx_shift_if #(
   parameter int WIDTH = ser_pkg::DEF_WIDTH
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             ser_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data, ser_ready,
      input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
   );

   modport slave (
      input  load_valid, load_data, ser_ready,
      output load_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
   );
endinterface

// File: rtl/ser_tx_shift_shreg.sv
// Parallel-load, shift-left-by-one register built from individual flip-flops.
// Load wins over shift; zero is shifted into bit 0.
module shreg_pl_sl1 #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] shiftIn;

   assign shiftIn = {q_o[WIDTH-2:0], 1'b0};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic bit_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            bit_q <= 1'b0;
         end else if (load_i) begin
            bit_q <= d_i[i];
         end else if (shift_i) begin
            bit_q <= shiftIn[i];
         end
      end

      assign q_o[i] = bit_q;
   end
endmodule

// File: rtl/ser_tx_shift.sv
// MSB-first parallel-to-serial transmitter with valid/ready load and serial beat handshakes.
// Defining SER_TX_PARITY_EN appends one even-parity beat after the data bits.
module ser_tx_shift
   import ser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic        clock,
   input logic        reset,
   ser_tx_shift_if.slave bus
);
   localparam int              FRAME_LEN = frameLen(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   serState_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             outEn_q;
   logic [WIDTH-1:0] shreg;
   logic             accept, beat, doLoad, doShift, inShift, txBit;

   assign accept  = bus.load_valid && bus.load_ready;
   assign beat    = bus.ser_valid && bus.ser_ready;
   assign inShift = (state_q == ST_SHIFT);

   // outEn_q keeps load_ready low until the first edge after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         outEn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         outEn_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      doLoad  = 1'b0;
      doShift = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               doLoad  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (beat) begin
               doShift = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   shreg_pl_sl1 #(.WIDTH(WIDTH)) u_shreg (
      .clock   (clock),
      .reset   (reset),
      .load_i  (doLoad),
      .shift_i (doShift),
      .d_i     (bus.load_data),
      .q_o     (shreg)
   );

`ifdef SER_TX_PARITY_EN
   logic parity_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         parity_q <= 1'b0;
      end else if (doLoad) begin
         parity_q <= ^bus.load_data;
      end
   end

   assign txBit = (cnt_q == LAST_CNT) ? parity_q : shreg[WIDTH-1];
`else
   assign txBit = shreg[WIDTH-1];
`endif

   assign bus.load_ready = (state_q == ST_IDLE) && outEn_q;
   assign bus.ser_out    = inShift && txBit;
   assign bus.ser_valid  = inShift;
   assign bus.ser_first  = inShift && (cnt_q == '0);
   assign bus.ser_last   = inShift && (cnt_q == LAST_CNT);
   assign bus.busy       = inShift;
   assign bus.done       = (state_q == ST_DONE);
endmodule
